// File: rtl/fir_decim_fifo.sv
// Post-FIR stage: drops the pipeline warm-up samples, keeps 1 of every DECIM samples,
// and buffers them in a first-word-fall-through FIFO behind a valid/ready stream.
module fir_decim_fifo #(
   parameter int DATA_W = 10,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 8,
   parameter int WARMUP = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic [DATA_W-1:0]          y_in,
   output logic [DATA_W-1:0]          m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [15:0]                ovf_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int PW   = AW + 1;
   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int WC_W = $clog2(WARMUP + 1);

   logic [WC_W-1:0]   warm_cnt_q, warm_cnt_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       ovf_count_q, ovf_count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic warm_done, capture, empty, full, pop, push, drop;

   assign warm_done = (warm_cnt_q == WC_W'(WARMUP));
   assign capture   = warm_done && (phase_q == '0);
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = m_valid & m_ready;
   // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
   assign push      = capture & (~full | pop);
   assign drop      = capture & full & ~pop;

   // NOTE: every variable gets its default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      warm_cnt_d  = warm_cnt_q;
      phase_d     = phase_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      ovf_count_d = ovf_count_q;
      if (clr) begin
         warm_cnt_d  = '0;
         phase_d     = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         ovf_count_d = '0;
      end else begin
         if (!warm_done) begin
            warm_cnt_d = warm_cnt_q + WC_W'(1);
         end else if (phase_q == PH_W'(DECIM - 1)) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + PH_W'(1);
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (drop) begin
            overflow_d = 1'b1;
            if (ovf_count_q != 16'hFFFF) ovf_count_d = ovf_count_q + 16'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt_q  <= '0;
         phase_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         ovf_count_q <= '0;
      end else begin
         warm_cnt_q  <= warm_cnt_d;
         phase_q     <= phase_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         ovf_count_q <= ovf_count_d;
      end
   end

   // NOTE: storage is not reset; stale entries are unreachable because the pointers are, and m_data is forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= y_in;
   end

   assign m_valid   = ~empty;
   assign m_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign level     = wr_ptr_q - rd_ptr_q;
   assign overflow  = overflow_q;
   assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: warm-up, bit-exactness, fill/overflow, full+pop,
// random backpressure against a queue model, and clr / async reset restarts.
module tb_fir_decim_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [9:0] y_in = '0;
   logic [9:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [3:0] level;
   logic       overflow;
   logic [15:0] ovf_count;

   int total = 0;
   int bad   = 0;

   fir_decim_fifo dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .y_in      (y_in),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .level     (level),
      .overflow  (overflow),
      .ovf_count (ovf_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one sample, take one rising edge, sample outputs 1 time unit later.
   task automatic tick(input logic [9:0] y);
      y_in = y;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   function automatic logic is_cap(input int e);
      return (e >= 64) && (((e - 64) % 4) == 0);
   endfunction

   // Reset, fill with m_ready=0 through edge 100 (2 drops), then pop 3 -> level 5, overflow 1.
   task automatic build_ovf_state(input string tag);
      do_reset();
      m_ready = 1'b0;
      for (int e = 0; e <= 100; e++) tick(e[9:0]);
      m_ready = 1'b1;
      for (int e = 101; e <= 103; e++) tick(e[9:0]);
      m_ready = 1'b0;
      check({tag, "_pre_level"}, level, 5);
      check({tag, "_pre_ovf"}, overflow, 1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, m_valid, 0);
      check({tag, "_level"}, level, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_ovfcnt"}, ovf_count, 0);
      check({tag, "_data"}, m_data, 0);
   endtask

   task automatic check_warmup(input string tag);
      m_ready = 1'b1;
      for (int e = 0; e <= 64; e++) begin
         tick(e[9:0]);
         check({tag, "_valid"}, m_valid, (e == 64));
      end
      check({tag, "_first"}, m_data, 64);
   endtask

   initial begin
      logic       exp_v;
      logic [9:0] y;
      logic [9:0] q[$];
      logic       pop_m;
      int         pops_seen;

      // Reset state
      do_reset();
      check_cleared("rst");

      // T1 warm-up and decimation
      m_ready = 1'b1;
      for (int e = 0; e <= 80; e++) begin
         tick(e[9:0]);
         exp_v = is_cap(e);
         check("t1_valid", m_valid, exp_v);
         check("t1_data", m_data, exp_v ? e : 0);
      end

      // T2 bit-exact extremes at capture edges 84, 88, 92
      for (int e = 81; e <= 92; e++) begin
         y = (e == 84) ? 10'h200 : (e == 88) ? 10'h1FF : (e == 92) ? 10'h3FF : e[9:0];
         tick(y);
         if (e == 84) check("t2_neg512", m_data, 10'h200);
         if (e == 88) check("t2_pos511", m_data, 10'h1FF);
         if (e == 92) check("t2_neg1", m_data, 10'h3FF);
      end

      // T3 fill and overflow with no consumer
      do_reset();
      m_ready = 1'b0;
      for (int e = 0; e <= 100; e++) begin
         tick(e[9:0]);
         if (e == 88) check("t3_level7", level, 7);
         if (e == 92) begin
            check("t3_level8", level, 8);
            check("t3_noovf", overflow, 0);
         end
         if (e == 96) check("t3_cnt1", ovf_count, 1);
      end
      check("t3_ovf", overflow, 1);
      check("t3_cnt2", ovf_count, 2);
      check("t3_level", level, 8);
      check("t3_head", m_data, 64);

      // T4 full FIFO with pop on exactly a capture edge
      do_reset();
      m_ready = 1'b0;
      for (int e = 0; e <= 95; e++) tick(e[9:0]);
      check("t4_full", level, 8);
      m_ready = 1'b1;
      tick(10'd96);
      check("t4_level", level, 8);
      check("t4_ovf", overflow, 0);
      check("t4_head", m_data, 68);
      for (int i = 1; i <= 7; i++) begin
         tick(10'(96 + i));
         check("t4_drain", m_data, 68 + 4 * i);
      end

      // T5 random backpressure against a queue model
      do_reset();
      q.delete();
      pops_seen = 0;
      for (int e = 0; e < 400; e++) begin
         m_ready = ($urandom_range(0, 1) == 1);
         pop_m   = (q.size() != 0) && m_ready;
         tick(e[9:0]);
         if (pop_m) begin
            void'(q.pop_front());
            pops_seen++;
         end
         if (is_cap(e) && q.size() < 8) q.push_back(e[9:0]);
         check("t5_valid", m_valid, (q.size() != 0));
         check("t5_level", level, q.size());
         check("t5_data", m_data, (q.size() != 0) ? q[0] : 10'd0);
      end
      check("t5_no_ovf", overflow, 0);
      check("t5_popped", (pops_seen > 40), 1);

      // T6a synchronous clr mid-stream (clr lands on a capture edge)
      build_ovf_state("t6a");
      clr = 1'b1;
      tick(10'd104);
      clr = 1'b0;
      check_cleared("t6a_clr");
      check_warmup("t6a_warm");

      // T6b asynchronous rst_n pulse between edges
      build_ovf_state("t6b");
      #2 rst_n = 1'b0;
      #1;
      check_cleared("t6b_rst");
      #1 rst_n = 1'b1;
      check_warmup("t6b_warm");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
